// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD tile drawing path.
//   CMD_*      : ILI9341-style command bytes used by the tile writer
//   state_e    : tile writer FSM states
//   LCD_*_DEF  : default panel geometry (portrait 240x320)
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int LCD_W_DEF = 240;
  localparam int LCD_H_DEF = 320;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    PIXEL
  } state_e;

endpackage

// File: rtl/lcd_tile_writer.sv
// Draws one solid-colour tile: emits CASET(xs,xe), PASET(ys,ye), RAMWR and
// then npix RGB565 pixels (high byte first) as a valid/ready byte stream.
// Ports:
//   clk, rstn             : clock, asynchronous active-low reset
//   start                 : draw request, honoured only while busy=0
//   col_start, row_start  : tile origin, latched on accepted start
//   color                 : RGB565 fill colour, latched on accepted start
//   busy                  : tile in progress
//   done                  : one-cycle pulse after the last byte is accepted
//   out_valid/out_ready   : byte handshake toward the LCD bus interface
//   out_data, out_dc      : byte and data/command flag (0 = command)
module lcd_tile_writer
  import lcd_pkg::*;
#(
  parameter int TILE_W = 20,
  parameter int TILE_H = 20,
  parameter int LCD_W  = LCD_W_DEF,
  parameter int LCD_H  = LCD_H_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] col_start,
  input  logic [15:0] row_start,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_dc
);

  localparam int NBYTES = 2 * TILE_W * TILE_H;
  localparam int CNT_W  = ($clog2(NBYTES) < 10) ? 10 : $clog2(NBYTES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;     // index of the final pixel byte
  logic [15:0]        xs_q, xs_d, xe_q, xe_d;
  logic [15:0]        ys_q, ys_d, ye_q, ye_d;
  logic [15:0]        color_q, color_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_dc_q, out_dc_d;

  // Window end and pixel count from the live inputs; 17-bit so sums never wrap.
  logic [16:0] xs_ext, ys_ext, xe_sum, ye_sum, xe_clip, ye_clip, w_ext, h_ext;
  logic [33:0] npix;
  logic        off_panel;
  logic        accept;

  assign xs_ext    = {1'b0, col_start};
  assign ys_ext    = {1'b0, row_start};
  assign xe_sum    = xs_ext + 17'(TILE_W - 1);
  assign ye_sum    = ys_ext + 17'(TILE_H - 1);
  assign xe_clip   = (xe_sum > 17'(LCD_W - 1)) ? 17'(LCD_W - 1) : xe_sum;
  assign ye_clip   = (ye_sum > 17'(LCD_H - 1)) ? 17'(LCD_H - 1) : ye_sum;
  assign w_ext     = xe_clip - xs_ext + 17'd1;
  assign h_ext     = ye_clip - ys_ext + 17'd1;
  assign npix      = 34'(w_ext) * 34'(h_ext);
  assign off_panel = (xs_ext >= 17'(LCD_W)) || (ys_ext >= 17'(LCD_H));
  assign accept    = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    color_d = color_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = col_start;
          ys_d    = row_start;
          color_d = color;
          xe_d    = 16'(xe_clip);
          ye_d    = 16'(ye_clip);
          last_d  = CNT_W'((npix << 1) - 34'd1);
          cnt_d   = '0;
          // An origin off the panel completes immediately with nothing emitted.
          if (off_panel) done_d = 1'b1;
          else           state_d = CASET;
        end
      end
      CASET: if (accept) begin
        if (cnt_q == CNT_W'(4)) begin
          state_d = PASET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PASET: if (accept) begin
        if (cnt_q == CNT_W'(4)) begin
          state_d = RAMWR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RAMWR: if (accept) begin
        state_d = PIXEL;
        cnt_d   = '0;
      end
      PIXEL: if (accept) begin
        if (cnt_q == last_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The output register always holds the byte selected by the next
    // (state, index); without acceptance both are unchanged, so the byte
    // is held stable across stalls.
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d != IDLE);
    out_dc_d    = 1'b1;
    out_data_d  = 8'h00;
    case (state_d)
      CASET: begin
        case (cnt_d[2:0])
          3'd0:    begin out_dc_d = 1'b0; out_data_d = CMD_CASET; end
          3'd1:    out_data_d = xs_d[15:8];
          3'd2:    out_data_d = xs_d[7:0];
          3'd3:    out_data_d = xe_d[15:8];
          default: out_data_d = xe_d[7:0];
        endcase
      end
      PASET: begin
        case (cnt_d[2:0])
          3'd0:    begin out_dc_d = 1'b0; out_data_d = CMD_PASET; end
          3'd1:    out_data_d = ys_d[15:8];
          3'd2:    out_data_d = ys_d[7:0];
          3'd3:    out_data_d = ye_d[15:8];
          default: out_data_d = ye_d[7:0];
        endcase
      end
      RAMWR: begin
        out_dc_d   = 1'b0;
        out_data_d = CMD_RAMWR;
      end
      PIXEL:   out_data_d = cnt_d[0] ? color_d[7:0] : color_d[15:8];
      default: out_dc_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      xs_q        <= '0;
      xe_q        <= '0;
      ys_q        <= '0;
      ye_q        <= '0;
      color_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_dc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dc_q    <= out_dc_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dc    = out_dc_q;

endmodule

// File: tb/tb_lcd_tile_writer.sv
// Scoreboard bench for lcd_tile_writer: the stimulus pushes the expected
// {dc,data} stream into a queue, the monitor pops and compares on every
// accepted byte and checks that stalled bytes are held.
module tb_lcd_tile_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] col_start, row_start, color;
  logic        busy, done, out_valid, out_ready, out_dc;
  logic [7:0]  out_data;

  lcd_tile_writer dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .col_start (col_start),
    .row_start (row_start),
    .color     (color),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dc    (out_dc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int acc_cnt = 0, stall_cnt = 0, done_cnt = 0;
  int t0, acc0, stall0, done0;
  int ready_mode = 0;
  logic [8:0] exp_q[$];

  // out_ready: always 1, or ~60% high in random mode
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 40);
    end
  end

  // Monitor
  initial begin
    logic       prev_stall;
    logic [8:0] prev_byte, e;
    prev_stall = 1'b0;
    prev_byte  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || {out_dc, out_data} !== prev_byte) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got valid=%0b byte=%03h want valid=1 byte=%03h",
                     cyc, out_valid, {out_dc, out_data}, prev_byte);
          end
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte cyc=%0d got %03h want none", cyc, {out_dc, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_dc, out_data} !== e) begin
              failures++;
              $display("FAIL stream_byte cyc=%0d got %03h want %03h", cyc, {out_dc, out_data}, e);
            end
          end
          acc_cnt++;
        end
        if (out_valid && !out_ready) stall_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_byte  = {out_dc, out_data};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_hdr(input logic [7:0] xsh, xsl, xeh, xel, ysh, ysl, yeh, yel);
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, xsh}); exp_q.push_back({1'b1, xsl});
    exp_q.push_back({1'b1, xeh}); exp_q.push_back({1'b1, xel});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, ysh}); exp_q.push_back({1'b1, ysl});
    exp_q.push_back({1'b1, yeh}); exp_q.push_back({1'b1, yel});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pix(input int n, input logic [15:0] c);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic mark();
    t0 = cyc; acc0 = acc_cnt; stall0 = stall_cnt; done0 = done_cnt;
  endtask

  // Start pulse in cycle 0; returns #1 into cycle 1.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
    @(posedge clk);
    #1;
    col_start = x; row_start = y; color = c; start = 1'b1;
    mark();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout got none want done within %0d cycles", budget);
    end
  endtask

  task automatic wait_bytes(input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (acc_cnt - acc0 >= n) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      checks++; failures++;
      $display("FAIL byte_timeout got %0d want %0d bytes", acc_cnt - acc0, n);
    end
  endtask

  task automatic finish_tile(input string name, input int nbytes, input int lat_exp, input int lat);
    #1;
    chk({name, "_latency"}, lat, lat_exp);
    chk({name, "_bytes"}, acc_cnt - acc0, nbytes);
    chk({name, "_done_count"}, done_cnt - done0, 1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_busy_at_done"}, busy, 0);
    $display("tile %s bytes=%0d done_latency=%0d stalls=%0d", name, acc_cnt - acc0, lat, stall_cnt - stall0);
  endtask

  initial begin
    int lat;
    rstn = 1'b0; start = 1'b0; col_start = '0; row_start = '0; color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_dc", out_dc, 0);
    rstn = 1'b1;

    // Origin (0,0), red, no backpressure
    push_hdr(8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13);
    push_pix(400, 16'hF800);
    issue(16'd0, 16'd0, 16'hF800);
    chk("t1_busy_c1", busy, 1);
    chk("t1_valid_c1", out_valid, 1);
    chk("t1_byte_c1", {out_dc, out_data}, 9'h02A);
    wait_done(5000, lat);
    finish_tile("t1", 811, 812, lat);

    // Origin (220,300); start held high for 3 cycles at byte 50 is ignored
    push_hdr(8'h00, 8'hDC, 8'h00, 8'hEF, 8'h01, 8'h2C, 8'h01, 8'h3F);
    push_pix(400, 16'h001F);
    issue(16'd220, 16'd300, 16'h001F);
    wait_bytes(50);
    @(posedge clk);
    #1;
    col_start = 16'd5; row_start = 16'd5; color = 16'h1234; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5000, lat);
    finish_tile("t2", 811, 812, lat);

    // Start in the done cycle: clipped tile at (230,310)
    push_hdr(8'h00, 8'hE6, 8'h00, 8'hEF, 8'h01, 8'h36, 8'h01, 8'h3F);
    push_pix(100, 16'hABCD);
    col_start = 16'd230; row_start = 16'd310; color = 16'hABCD; start = 1'b1;
    mark();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t3_busy_c1", busy, 1);
    chk("t3_byte_c1", {out_dc, out_data}, 9'h02A);
    wait_done(5000, lat);
    finish_tile("t3", 211, 212, lat);

    // Random backpressure: same stream, done delayed by one cycle per stall
    ready_mode = 1;
    push_hdr(8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13);
    push_pix(400, 16'hF800);
    issue(16'd0, 16'd0, 16'hF800);
    wait_done(8000, lat);
    finish_tile("t4", 811, 812 + (stall_cnt - stall0), lat);
    ready_mode = 0;
    chk("t4_saw_stalls", (stall_cnt - stall0) > 0, 1);

    // Off-panel origin: immediate done, nothing emitted
    issue(16'd240, 16'd0, 16'hFFFF);
    chk("t5_done_c1", done, 1);
    chk("t5_busy_c1", busy, 0);
    chk("t5_valid_c1", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_bytes", acc_cnt - acc0, 0);
    chk("t5_done_count", done_cnt - done0, 1);
    $display("tile t5 off-panel bytes=%0d", acc_cnt - acc0);

    // Reset at byte 300
    push_hdr(8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13);
    push_pix(400, 16'h07E0);
    issue(16'd0, 16'd0, 16'h07E0);
    wait_bytes(300);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_dc", out_dc, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt - done0, 0);
    chk("t6_idle_busy", busy, 0);
    $display("tile t6 aborted after %0d bytes", acc_cnt - acc0);

    // Fresh full tile after the abort
    push_hdr(8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13);
    push_pix(400, 16'h07E0);
    issue(16'd0, 16'd0, 16'h07E0);
    wait_done(5000, lat);
    finish_tile("t7", 811, 812, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
